smult_seq_arb: RTL
==================

Name: smult_seq_arb

Overview:
- Round-robin scheduler and lane sequencer that shares one external 16-bit half-precision scalar multiplier (SMUL, combinational) between two requesters.
- Each granted request is a scalar-by-16-lane vector multiply.
- The block captures the operands, feeds one lane per cycle to the multiplier, assembles the 256-bit product, tracks a sticky overflow, and pulses a per-requester done.
- It is the low-area alternative to a fully parallel 16-multiplier array in the vector unit.

Parameters:
- LANES, 16, number of 16-bit lanes per vector.
- WIDTH, 16, lane and scalar width in bits (half precision).

Ports:
- clk1  in  1  system clock; all state updates on its rising edge.
- rst  in  1  synchronous, active-high reset.
- req  in  2  request per requester; held high until that requester's done.
- scalar0  in  WIDTH  scalar operand, requester 0.
- vecin0  in  LANES*WIDTH  vector operand, requester 0; lane i = bits [16i+15:16i].
- scalar1  in  WIDTH  scalar operand, requester 1.
- vecin1  in  LANES*WIDTH  vector operand, requester 1.
- mul_a  out  WIDTH  lane operand to the shared SMUL.
- mul_b  out  WIDTH  scalar operand to the shared SMUL.
- mul_p  in  WIDTH  SMUL product (combinational from mul_a/mul_b).
- mul_ov  in  1  SMUL overflow flag.
- gnt  out  2  one-hot grant, held from MUL entry through DONE.
- busy  out  1  high whenever state is not IDLE.
- product  out  LANES*WIDTH  assembled result register.
- V  out  1  sticky OR of mul_ov over all lanes of the current operation.
- done  out  2  one-cycle pulse to the granted requester.

Behaviour:
- Reset (synchronous, rst=1 at an edge): state=IDLE, idx=0, gnt=0, done=0, busy=0, product=0, V=0, last=1 (so requester 0 wins the first tie), captured operands=0. Reset mid-operation aborts immediately, no done pulse is issued, and the op is lost.
- States: IDLE, MUL, DONE (encoding in package).
- IDLE:
  - mul_a=mul_b=0.
  - If any req is high at the edge, the arbiter picks a winner. With a single request, that requester wins. With both, the requester that is not "last" wins.
  - On grant: set gnt (one-hot), last=winner; capture scalar and vecin of the winner into internal registers; clear product and V; idx=0; go to MUL.
  - No request: stay in IDLE.
- MUL:
  - mul_a = captured lane idx; mul_b = captured scalar.
  - At each edge: product lane idx <= mul_p; V <= V | mul_ov; idx++.
  - When idx = LANES-1 at the edge, go to DONE and reset idx to 0.
  - Exactly LANES cycles in MUL.
- DONE: done[gnt] = 1 for this cycle only; product and V are valid. Next state is IDLE with gnt cleared. Requests are not sampled in DONE.
- Latency: with req sampled in IDLE in cycle 0, MUL occupies cycles 1..16, done is high in cycle 17, and the block is back in IDLE in cycle 18. Back-to-back throughput is one op per LANES+2 cycles.
- Requester obligations:
  - Drop req at the edge ending its done cycle; a req still high in the following IDLE is a new request.
  - Deasserting req mid-op is ignored; the op completes and done still pulses.
- Operand changes after the grant edge do not affect the result.
- product and V hold their values after DONE until the next grant clears them.
- Arithmetic is delegated entirely to SMUL; this block performs no width conversion. Lane i of product maps to lane i of vecin.

Decomposition:
- Package smult_pkg:
  - LANES, WIDTH.
  - State encoding: IDLE=2'd0, MUL=2'd1, DONE=2'd2.
  - FP16 constants ONE=16'h3c00, NEG_ONE=16'hbc00, POS_INF=16'h7c00.
- Sub-module rr_arb2: a two-way round-robin arbiter. Inputs req[1:0] and last; output one-hot win. Purely combinational; the last-grant register stays in the parent.
- SMUL is instantiated by the parent integration, not inside this block.

Test Plan:
1. After reset, req=01, scalar0=3c00, vecin0=all lanes 3c00 -> gnt=01 in cycles 1..17, done=01 only in cycle 17, product=all 3c00, V=0.
2. After reset, req=11 held. Requester 0 has scalar bc00 on vector all 3c00; requester 1 has scalar 3c80 on vector all 0201. -> done=01 in cycle 17 with product all bc00; then gnt=10 from cycle 19 and done=10 in cycle 35 with product all 0241.
3. Both requesters re-request immediately after each done for 4 ops -> grant order is 0,1,0,1; never the same requester twice while the other is waiting.
4. scalar0=7bff, vecin0 lane 5=4000, other lanes 3c00 -> lane 5=7c00, other lanes 7bff, V=1. A following clean op (scenario 1) returns V=0.
5. Assert rst in MUL cycle 8 -> next cycle busy=0, gnt=0, product=0, V=0, no done pulse. A new req=10 then completes normally with done=10 in cycle 17 relative to its request.
6. Change vecin0 to all 0000 in cycle 2 of an op started with vecin0 all 3c00 and scalar 3c00 -> product=all 3c00. mul_a = 0 in IDLE throughout.

Source files
------------

// File: rtl/smult_pkg.sv
// Shared constants and state encoding for the scalar-by-vector multiply sequencer.
package smult_pkg;

    localparam int unsigned LANES = 16;
    localparam int unsigned WIDTH = 16;
    localparam int unsigned IDX_W = $clog2(LANES);

    typedef enum logic [1:0] {
        StIdle = 2'd0,
        StMul  = 2'd1,
        StDone = 2'd2
    } state_e;

    localparam logic [WIDTH-1:0] FP16_ONE     = 16'h3c00;
    localparam logic [WIDTH-1:0] FP16_NEG_ONE = 16'hbc00;
    localparam logic [WIDTH-1:0] FP16_POS_INF = 16'h7c00;

endpackage

// File: rtl/rr_arb2.sv
// Two-way round-robin arbiter; last_i is the index of the previous winner.
module rr_arb2 (
    input  logic [1:0] req_i,
    input  logic       last_i,
    output logic [1:0] win_o
);

    always_comb begin
        win_o = 2'b00;
        unique case (req_i)
            2'b01:   win_o = 2'b01;
            2'b10:   win_o = 2'b10;
            2'b11:   win_o = last_i ? 2'b01 : 2'b10;
            default: win_o = 2'b00;
        endcase
    end

endmodule

// File: rtl/smult_seq_arb.sv
// Shares one external FP16 multiplier between two requesters, feeding one lane
// per cycle and assembling the full vector product.
module smult_seq_arb
    import smult_pkg::*;
(
    input  logic                   clk1,
    input  logic                   rst,
    input  logic [1:0]             req,
    input  logic [WIDTH-1:0]       scalar0,
    input  logic [LANES*WIDTH-1:0] vecin0,
    input  logic [WIDTH-1:0]       scalar1,
    input  logic [LANES*WIDTH-1:0] vecin1,
    output logic [WIDTH-1:0]       mul_a,
    output logic [WIDTH-1:0]       mul_b,
    input  logic [WIDTH-1:0]       mul_p,
    input  logic                   mul_ov,
    output logic [1:0]             gnt,
    output logic                   busy,
    output logic [LANES*WIDTH-1:0] product,
    output logic                   V,
    output logic [1:0]             done
);

    state_e                        state_q, state_d;
    logic [IDX_W-1:0]              idx_q, idx_d;
    logic [1:0]                    gnt_q, gnt_d;
    logic                          last_q, last_d;
    logic                          v_q, v_d;
    logic [WIDTH-1:0]              scalar_q, scalar_d;
    logic [LANES-1:0][WIDTH-1:0]   vec_q, vec_d;
    logic [LANES-1:0][WIDTH-1:0]   product_q, product_d;
    logic [1:0]                    win;

    rr_arb2 u_arb (
        .req_i  (req),
        .last_i (last_q),
        .win_o  (win)
    );

    always_comb begin
        state_d   = state_q;
        idx_d     = idx_q;
        gnt_d     = gnt_q;
        last_d    = last_q;
        v_d       = v_q;
        scalar_d  = scalar_q;
        vec_d     = vec_q;
        product_d = product_q;
        mul_a     = '0;
        mul_b     = '0;

        unique case (state_q)
            StIdle: begin
                if (|req) begin
                    gnt_d     = win;
                    last_d    = win[1];
                    scalar_d  = win[1] ? scalar1 : scalar0;
                    vec_d     = win[1] ? vecin1 : vecin0;
                    product_d = '0;
                    v_d       = 1'b0;
                    idx_d     = '0;
                    state_d   = StMul;
                end
            end
            StMul: begin
                mul_a             = vec_q[idx_q];
                mul_b             = scalar_q;
                product_d[idx_q]  = mul_p;
                v_d               = v_q | mul_ov;
                if (idx_q == IDX_W'(LANES - 1)) begin
                    idx_d   = '0;
                    state_d = StDone;
                end else begin
                    idx_d = idx_q + 1'b1;
                end
            end
            StDone: begin
                gnt_d   = 2'b00;
                state_d = StIdle;
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk1) begin
        if (rst) begin
            state_q   <= StIdle;
            idx_q     <= '0;
            gnt_q     <= 2'b00;
            last_q    <= 1'b1;
            v_q       <= 1'b0;
            scalar_q  <= '0;
            vec_q     <= '0;
            product_q <= '0;
        end else begin
            state_q   <= state_d;
            idx_q     <= idx_d;
            gnt_q     <= gnt_d;
            last_q    <= last_d;
            v_q       <= v_d;
            scalar_q  <= scalar_d;
            vec_q     <= vec_d;
            product_q <= product_d;
        end
    end

    assign gnt     = gnt_q;
    assign busy    = (state_q != StIdle);
    assign done    = (state_q == StDone) ? gnt_q : 2'b00;
    assign product = product_q;
    assign V       = v_q;

endmodule
